// File: rtl/encode_scan.sv
// rtl/encode_scan.sv - serialises a request vector into one index beat per set bit
//
// Accepts a WIDTH-bit vector, then emits the binary index of each set bit
// as its own output beat, lowest-first (MSB_FIRST=0) or highest-first
// (MSB_FIRST=1). An all-zero vector yields a single beat flagged out_zero.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   in_valid   in_vec is valid this cycle
//   in_ready   block accepts a new vector this cycle (IDLE, out of reset)
//   in_vec     request vector, any number of bits set
//   out_valid  out_idx/out_last/out_zero are valid
//   out_ready  downstream accepts the current beat
//   out_idx    binary index of the bit reported by this beat
//   out_last   this beat is the final one for the accepted vector
//   out_zero   accepted vector was all-zero; beat carries no index

module encode_scan #(
   parameter int WIDTH     = 16,
   parameter bit MSB_FIRST = 1'b0,
   localparam int IDXW     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDXW-1:0]  out_idx,
   output logic             out_last,
   output logic             out_zero
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] pend, pend_nxt;
   logic [WIDTH-1:0] sel;       // one-hot of the bit reported this beat
   logic [IDXW-1:0]  idx;
   logic             single;    // pend has at most one bit set

   // Priority pick. The scan runs away from the preferred end so the
   // last hit written is the one that wins.
   always_comb begin
      sel = '0;
      idx = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (pend[i]) begin
               sel    = '0;
               sel[i] = 1'b1;
               idx    = IDXW'(i);
            end
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend[i]) begin
               sel    = '0;
               sel[i] = 1'b1;
               idx    = IDXW'(i);
            end
         end
      end
   end

   // Clearing the lowest set bit leaves zero iff at most one bit was set.
   assign single = ((pend & (pend - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pend  <= '0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_idx   = '0;
      out_last  = 1'b0;
      out_zero  = 1'b0;
      case (state)
         IDLE: begin
            // Held low while reset is asserted so nothing appears accepted.
            in_ready = rst_n;
            if (in_valid) begin
               pend_nxt  = in_vec;
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            out_valid = 1'b1;
            out_idx   = idx;
            out_last  = single;
            // pend only reaches zero in EMIT when the captured vector was zero;
            // a non-zero vector leaves EMIT on the handshake that empties it.
            out_zero  = (pend == '0);
            if (out_ready) begin
               pend_nxt = pend & ~sel;
               if (single) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_encode_scan.sv
// tb/tb_encode_scan.sv - self-checking bench for encode_scan (three configurations)

module tb_encode_scan;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  in_valid;
   logic [2:0]  out_ready;
   logic [15:0] in_vec [3];
   logic [2:0]  in_ready, out_valid, out_last, out_zero;
   logic [3:0]  out_idx [3];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // 0: WIDTH=16 lowest-first, 1: WIDTH=16 highest-first, 2: WIDTH=10 lowest-first
   encode_scan #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_vec(in_vec[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_idx(out_idx[0]), .out_last(out_last[0]), .out_zero(out_zero[0]));

   encode_scan #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_vec(in_vec[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_idx(out_idx[1]), .out_last(out_last[1]), .out_zero(out_zero[1]));

   encode_scan #(.WIDTH(10), .MSB_FIRST(1'b0)) u_w10 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_vec(in_vec[2][9:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_idx(out_idx[2]), .out_last(out_last[2]), .out_zero(out_zero[2]));

   function automatic void chk(string name, int k, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%0d want=%0d at %0t", name, k, act, exp, $time);
      end
   endfunction

   // ---------------- model: a queue of expected beats per instance ----------------
   int qbuf [3][40];
   int qh [3];
   int qc [3];
   bit busy [3];

   function automatic int width_of(int k);
      return (k == 2) ? 10 : 16;
   endfunction

   function automatic bit msb_of(int k);
      return (k == 1);
   endfunction

   // -1 encodes the single beat of an all-zero vector
   function automatic void push(int k, logic [15:0] v);
      int w;
      int n;
      int i;
      w = width_of(k);
      n = 0;
      for (int j = 0; j < w; j++) begin
         i = msb_of(k) ? (w - 1 - j) : j;
         if (v[i]) begin
            qbuf[k][n] = i;
            n++;
         end
      end
      if (n == 0) begin
         qbuf[k][0] = -1;
         n = 1;
      end
      qh[k]   = 0;
      qc[k]   = n;
      busy[k] = 1'b1;
   endfunction

   initial begin
      for (int k = 0; k < 3; k++) begin
         busy[k] = 1'b0;
         qh[k] = 0;
         qc[k] = 0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
               busy[k] = 1'b0;
               qh[k] = 0;
               qc[k] = 0;
            end
         end else begin
            for (int k = 0; k < 3; k++) begin
               if (busy[k]) begin
                  if (out_ready[k]) begin
                     qh[k]++;
                     qc[k]--;
                     if (qc[k] == 0) busy[k] = 1'b0;
                  end
               end else if (in_valid[k]) begin
                  push(k, in_vec[k]);
               end
            end
         end
      end
   end

   // ---------------- compare + beat log (DUT beats actually taken) ----------------
   int log_idx  [3][64];
   int log_last [3][64];
   int log_zero [3][64];
   int log_n [3];

   initial begin
      int e;
      for (int k = 0; k < 3; k++) log_n[k] = 0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
               chk("rst_in_ready", k, in_ready[k], 0);
               chk("rst_out_valid", k, out_valid[k], 0);
               chk("rst_out_idx", k, out_idx[k], 0);
               chk("rst_out_last", k, out_last[k], 0);
               chk("rst_out_zero", k, out_zero[k], 0);
            end else if (busy[k]) begin
               e = qbuf[k][qh[k]];
               chk("emit_in_ready", k, in_ready[k], 0);
               chk("emit_out_valid", k, out_valid[k], 1);
               chk("emit_out_idx", k, out_idx[k], (e < 0) ? 0 : e);
               chk("emit_out_last", k, out_last[k], (qc[k] == 1) ? 1 : 0);
               chk("emit_out_zero", k, out_zero[k], (e < 0) ? 1 : 0);
            end else begin
               chk("idle_in_ready", k, in_ready[k], 1);
               chk("idle_out_valid", k, out_valid[k], 0);
               chk("idle_out_idx", k, out_idx[k], 0);
               chk("idle_out_last", k, out_last[k], 0);
               chk("idle_out_zero", k, out_zero[k], 0);
            end
            if (rst_n && out_valid[k] && out_ready[k] && log_n[k] < 64) begin
               log_idx[k][log_n[k]]  = out_idx[k];
               log_last[k][log_n[k]] = out_last[k];
               log_zero[k][log_n[k]] = out_zero[k];
               log_n[k]++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(int k, logic [15:0] v);
      in_valid[k] = 1'b1;
      in_vec[k]   = v;
      tick();
      in_valid[k] = 1'b0;
      in_vec[k]   = 16'h0;
   endtask

   task automatic wait_idle(int k, output int n);
      n = 0;
      while (busy[k] && n < 200) begin
         tick();
         n++;
      end
      if (busy[k]) chk("timeout", k, 1, 0);
   endtask

   task automatic beat(string nm, int k, int pos, int idx, int last, int zero);
      chk({nm, "_idx"}, k, log_idx[k][pos], idx);
      chk({nm, "_last"}, k, log_last[k][pos], last);
      chk({nm, "_zero"}, k, log_zero[k][pos], zero);
   endtask

   task automatic run_rand(int k, logic [15:0] v);
      int n;
      n = 0;
      send(k, v);
      while (busy[k] && n < 300) begin
         out_ready[k] = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      if (busy[k]) chk("rand_timeout", k, 1, 0);
      out_ready[k] = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int n;
      logic [15:0] vecs [7];
      vecs = '{16'h0020, 16'h8000, 16'h0001, 16'hA5A5, 16'hFFFF, 16'h0000, 16'h0003};

      rst_n     = 1'b0;
      in_valid  = '0;
      out_ready = '0;
      for (int k = 0; k < 3; k++) in_vec[k] = 16'h0;

      repeat (2) @(posedge clk);
      #1;
      chk("lit_rst_in_ready", 0, in_ready[0], 0);
      chk("lit_rst_out_valid", 0, out_valid[0], 0);
      rst_n = 1'b1;
      #1;
      chk("lit_post_rst_in_ready", 0, in_ready[0], 1);
      tick();

      // one-hot 16'h0200 -> single beat idx 9, in_ready back the cycle after
      out_ready[0] = 1'b1;
      s = log_n[0];
      send(0, 16'h0200);
      @(negedge clk);
      chk("lit_oh_valid", 0, out_valid[0], 1);
      chk("lit_oh_idx", 0, out_idx[0], 9);
      chk("lit_oh_last", 0, out_last[0], 1);
      chk("lit_oh_zero", 0, out_zero[0], 0);
      tick();
      chk("lit_oh_in_ready", 0, in_ready[0], 1);
      chk("lit_oh_done_valid", 0, out_valid[0], 0);
      chk("lit_oh_count", 0, log_n[0] - s, 1);

      // 16'h8105 lowest-first, no stalls: 0,2,8,15 on consecutive cycles
      s = log_n[0];
      send(0, 16'h8105);
      wait_idle(0, n);
      chk("lit_8105_cycles", 0, n, 4);
      chk("lit_8105_count", 0, log_n[0] - s, 4);
      beat("lit_8105_b0", 0, s + 0, 0, 0, 0);
      beat("lit_8105_b1", 0, s + 1, 2, 0, 0);
      beat("lit_8105_b2", 0, s + 2, 8, 0, 0);
      beat("lit_8105_b3", 0, s + 3, 15, 1, 0);

      // same vector highest-first, out_ready toggling 1,0,1,0...
      s = log_n[1];
      send(1, 16'h8105);
      out_ready[1] = 1'b1;
      n = 0;
      while (busy[1] && n < 50) begin
         tick();
         out_ready[1] = ~out_ready[1];
         n++;
      end
      out_ready[1] = 1'b1;
      chk("lit_msb_cycles", 1, n, 7);
      chk("lit_msb_count", 1, log_n[1] - s, 4);
      beat("lit_msb_b0", 1, s + 0, 15, 0, 0);
      beat("lit_msb_b1", 1, s + 1, 8, 0, 0);
      beat("lit_msb_b2", 1, s + 2, 2, 0, 0);
      beat("lit_msb_b3", 1, s + 3, 0, 1, 0);

      // all-zero vector; a vector presented during its beat must be ignored
      s = log_n[0];
      in_valid[0] = 1'b1;
      in_vec[0]   = 16'h0000;
      tick();
      in_vec[0]   = 16'hFFFF;
      @(negedge clk);
      chk("lit_zero_valid", 0, out_valid[0], 1);
      chk("lit_zero_flag", 0, out_zero[0], 1);
      chk("lit_zero_last", 0, out_last[0], 1);
      chk("lit_zero_idx", 0, out_idx[0], 0);
      tick();
      in_valid[0] = 1'b0;
      in_vec[0]   = 16'h0;
      tick();
      chk("lit_zero_no_capture", 0, out_valid[0], 0);
      chk("lit_zero_count", 0, log_n[0] - s, 1);

      // WIDTH=10 all-ones, reset after third beat
      out_ready[2] = 1'b1;
      s = log_n[2];
      send(2, 16'h03FF);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("lit_async_valid", 2, out_valid[2], 0);
      chk("lit_async_idx", 2, out_idx[2], 0);
      chk("lit_async_last", 2, out_last[2], 0);
      chk("lit_async_in_ready", 2, in_ready[2], 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("lit_rel_in_ready", 2, in_ready[2], 1);
      repeat (5) tick();
      chk("lit_abort_count", 2, log_n[2] - s, 3);
      beat("lit_abort_b0", 2, s + 0, 0, 0, 0);
      beat("lit_abort_b2", 2, s + 2, 2, 0, 0);
      s = log_n[2];
      send(2, 16'h0200);
      wait_idle(2, n);
      chk("lit_w10_count", 2, log_n[2] - s, 1);
      beat("lit_w10_b0", 2, s, 9, 1, 0);

      // table of vectors through every configuration with random backpressure
      for (int k = 0; k < 3; k++) begin
         for (int v = 0; v < 7; v++) begin
            run_rand(k, vecs[v]);
            tick();
         end
      end
      s = log_n[0];
      send(0, 16'h0020);
      wait_idle(0, n);
      beat("lit_onehot5", 0, s, 5, 1, 0);

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
